// File: rtl/tmip_action_sched.sv
// rtl/tmip_action_sched.sv - TMIP action-list sequencer
//
// Buffers one action set (up to DEPTH codes) and issues it to the image
// datapath one command at a time. It tracks the running image side length
// and ping-pong SRAM bank selection between commands.
// Optional feature macro: TMIP_SKIP_NOP_EN. When defined, size-neutral
// resizes are consumed internally instead of being issued.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, img_size    image-load frame; side length taken on its first cycle
//   in_valid_2, action    action-set frame, one action code per cycle
//   dp_ready, dp_done     datapath accept and one-cycle completion pulse
//   cmd_valid, cmd_op,    command offer: action code, side length before the
//   cmd_size, cmd_src_bank,  action, and the SRAM banks to read and write
//   cmd_dst_bank
//   busy                  sequencer is not idle
//   seq_done              one-cycle pulse after the final command completes
//   err_overflow          sticky; the last action set exceeded DEPTH entries
module tmip_action_sched #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [4:0] img_size,
  input  logic       in_valid_2,
  input  logic [2:0] action,
  input  logic       dp_ready,
  input  logic       dp_done,
  output logic       cmd_valid,
  output logic [2:0] cmd_op,
  output logic [4:0] cmd_size,
  output logic [1:0] cmd_src_bank,
  output logic [1:0] cmd_dst_bank,
  output logic       busy,
  output logic       seq_done,
  output logic       err_overflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  state_e           state_q;
  logic             in_valid_q;
  logic [4:0]       base_size_q;
  logic [CNT_W-1:0] wr_cnt_q;
  logic [CNT_W-1:0] rd_ptr_q;
  logic [2:0]       mem_q [DEPTH];

  logic             cmd_valid_q;
  logic [2:0]       cmd_op_q;
  logic [4:0]       cmd_size_q;
  logic [1:0]       cmd_src_q;
  logic [1:0]       cmd_dst_q;
  logic             seq_done_q;
  logic             err_q;

  // Next-command values, used whenever a new entry is loaded into ISSUE.
  logic             load_en;
  logic [CNT_W-1:0] rd_ptr_d;
  logic [2:0]       cmd_op_d;
  logic [4:0]       cmd_size_d;
  logic [1:0]       cmd_src_d;
  logic [1:0]       cmd_dst_d;
  logic             cmd_nop_d;

  logic [CNT_W-1:0] adv_ptr;
  logic [2:0]       adv_op;
  logic [4:0]       size_after;

  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;

  always_comb begin
    adv_ptr = rd_ptr_q + CNT_W'(1);
    // Running off the end of the buffer yields an implicit cross-correlation.
    adv_op  = (adv_ptr < wr_cnt_q) ? mem_q[adv_ptr[PTR_W-1:0]] : 3'd0;

    size_after = cmd_size_q;
    case (cmd_op_q)
      3'd1, 3'd7: if (cmd_size_q > 5'd4)  size_after = cmd_size_q >> 1;
      3'd6:       if (cmd_size_q < 5'd16) size_after = cmd_size_q << 1;
      default:    size_after = cmd_size_q;
    endcase

    load_en    = 1'b0;
    rd_ptr_d   = '0;
    cmd_op_d   = mem_q[0];
    cmd_size_d = base_size_q;
    cmd_src_d  = 2'd0;
    case (state_q)
      CAPTURE: begin
        // Each set restarts from the original image in bank 0.
        if (!in_valid_2) load_en = 1'b1;
      end
      ISSUE: begin
        // A skipped size-neutral action: advance without touching banks.
        if (!cmd_valid_q) begin
          load_en    = 1'b1;
          rd_ptr_d   = adv_ptr;
          cmd_op_d   = adv_op;
          cmd_size_d = cmd_size_q;
          cmd_src_d  = cmd_src_q;
        end
      end
      WAIT: begin
        if (dp_done && (cmd_op_q != 3'd0)) begin
          load_en    = 1'b1;
          rd_ptr_d   = adv_ptr;
          cmd_op_d   = adv_op;
          cmd_size_d = size_after;
          cmd_src_d  = cmd_dst_q;
        end
      end
      default: load_en = 1'b0;
    endcase

    // Cross-correlation writes nothing, so it keeps the source bank.
    if (cmd_op_d == 3'd0)       cmd_dst_d = cmd_src_d;
    else if (cmd_src_d == 2'd1) cmd_dst_d = 2'd2;
    else                        cmd_dst_d = 2'd1;

`ifdef TMIP_SKIP_NOP_EN
    cmd_nop_d = (((cmd_op_d == 3'd1) || (cmd_op_d == 3'd7)) && (cmd_size_d <= 5'd4)) ||
                ((cmd_op_d == 3'd6) && (cmd_size_d >= 5'd16));
`else
    cmd_nop_d = 1'b0;
`endif

    wr_en   = in_valid_2 && ((state_q == IDLE) ||
              ((state_q == CAPTURE) && (wr_cnt_q < CNT_W'(DEPTH))));
    wr_addr = (state_q == IDLE) ? '0 : wr_cnt_q[PTR_W-1:0];
  end

  // Action storage needs no reset: entries are only read below wr_cnt_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= action;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_valid_q  <= 1'b0;
      base_size_q <= '0;
      wr_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      cmd_size_q  <= '0;
      cmd_src_q   <= '0;
      cmd_dst_q   <= '0;
      seq_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      in_valid_q <= in_valid;
      case (state_q)
        IDLE: begin
          if (in_valid && !in_valid_q) base_size_q <= img_size;
          if (in_valid_2) begin
            wr_cnt_q <= CNT_W'(1);
            err_q    <= 1'b0;
            state_q  <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (in_valid_2) begin
            if (wr_cnt_q < CNT_W'(DEPTH)) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            else                          err_q    <= 1'b1;
          end
        end
        ISSUE: begin
          if (cmd_valid_q && dp_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (dp_done && (cmd_op_q == 3'd0)) begin
            seq_done_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          seq_done_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (load_en) begin
        rd_ptr_q    <= rd_ptr_d;
        cmd_op_q    <= cmd_op_d;
        cmd_size_q  <= cmd_size_d;
        cmd_src_q   <= cmd_src_d;
        cmd_dst_q   <= cmd_dst_d;
        cmd_valid_q <= !cmd_nop_d;
        state_q     <= ISSUE;
      end
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_op       = cmd_op_q;
  assign cmd_size     = cmd_size_q;
  assign cmd_src_bank = cmd_src_q;
  assign cmd_dst_bank = cmd_dst_q;
  assign busy         = (state_q != IDLE);
  assign seq_done     = seq_done_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_tmip_action_sched.sv
// tb/tb_tmip_action_sched.sv - scoreboard bench for tmip_action_sched
module tb_tmip_action_sched;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] img_size = '0;
  logic       in_valid_2 = 1'b0;
  logic [2:0] action = '0;
  logic       dp_ready = 1'b1;
  logic       dp_done = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [4:0] cmd_size;
  logic [1:0] cmd_src_bank;
  logic [1:0] cmd_dst_bank;
  logic       busy;
  logic       seq_done;
  logic       err_overflow;

  tmip_action_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .img_size(img_size),
    .in_valid_2(in_valid_2), .action(action), .dp_ready(dp_ready), .dp_done(dp_done),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_size(cmd_size),
    .cmd_src_bank(cmd_src_bank), .cmd_dst_bank(cmd_dst_bank), .busy(busy),
    .seq_done(seq_done), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [4:0] size;
    logic [1:0] src;
    logic [1:0] dst;
  } cmd_t;

  cmd_t       exp_q[$];
  logic [2:0] act_q[$];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input int op, input int size, input int src, input int dst);
    cmd_t c;
    c.op = 3'(op); c.size = 5'(size); c.src = 2'(src); c.dst = 2'(dst);
    return c;
  endfunction

  // Monitor: every accepted command is compared against the scoreboard.
  always @(negedge clk) begin : monitor
    cmd_t e;
    if (rst_n && cmd_valid && dp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_cmd: got op %0d size %0d src %0d dst %0d expected none",
                 cmd_op, cmd_size, cmd_src_bank, cmd_dst_bank);
      end else begin
        e = exp_q.pop_front();
        chk("cmd_op", int'(cmd_op), int'(e.op));
        chk("cmd_size", int'(cmd_size), int'(e.size));
        chk("cmd_src_bank", int'(cmd_src_bank), int'(e.src));
        chk("cmd_dst_bank", int'(cmd_dst_bank), int'(e.dst));
      end
    end
  end

  // Datapath model: completes each accepted command a few cycles later.
  initial begin : datapath
    forever begin
      @(negedge clk);
      if (rst_n && cmd_valid && dp_ready) begin
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 dp_done = 1'b1;
        @(posedge clk);
        #1 dp_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Two-cycle load frame; the second cycle carries a different size that must be ignored.
  task automatic load_image(input logic [4:0] s);
    in_valid = 1'b1;
    img_size = s;
    tick();
    img_size = (s == 5'd8) ? 5'd4 : 5'd8;
    tick();
    in_valid = 1'b0;
    img_size = '0;
  endtask

  task automatic send_actions;
    foreach (act_q[i]) begin
      in_valid_2 = 1'b1;
      action = act_q[i];
      tick();
    end
    in_valid_2 = 1'b0;
    action = '0;
  endtask

  task automatic wait_seq(input string name);
    int got;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (seq_done) begin
        got = 1;
        break;
      end
    end
    chk({name, "_seq_done_seen"}, got, 1);
    @(negedge clk);
    chk({name, "_seq_done_pulse"}, int'(seq_done), 0);
    chk({name, "_idle_after"}, int'(busy), 0);
    chk({name, "_scoreboard_left"}, exp_q.size(), 0);
    tick();
  endtask

  initial begin : stimulus
    int acc;
    int seen;

    // Reset state
    repeat (3) tick();
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_seq_done", int'(seq_done), 0);
    chk("rst_err", int'(err_overflow), 0);
    chk("rst_cmd_fields", int'({cmd_op, cmd_size, cmd_src_bank, cmd_dst_bank}), 0);
    rst_n = 1'b1;
    tick();

    // T1: size 8, {1,6,0}
    exp_q.push_back(mk(1, 8, 0, 1));
    exp_q.push_back(mk(6, 4, 1, 2));
    exp_q.push_back(mk(0, 8, 2, 2));
    load_image(5'd8);
    act_q = '{3'd1, 3'd6, 3'd0};
    send_actions();
    @(negedge clk);
    chk("t1_capture_busy", int'(busy), 1);
    chk("t1_cmd_valid_before", int'(cmd_valid), 0);
    @(negedge clk);
    chk("t1_cmd_valid_first", int'(cmd_valid), 1);
    wait_seq("t1");

    // T2: size 4, {1,0}
    load_image(5'd4);
`ifdef TMIP_SKIP_NOP_EN
    exp_q.push_back(mk(0, 4, 0, 0));
`else
    exp_q.push_back(mk(1, 4, 0, 1));
    exp_q.push_back(mk(0, 4, 1, 1));
`endif
    act_q = '{3'd1, 3'd0};
    send_actions();
    wait_seq("t2");

    // T3: size 16, {2,3}, implicit terminator
    load_image(5'd16);
    exp_q.push_back(mk(2, 16, 0, 1));
    exp_q.push_back(mk(3, 16, 1, 2));
    exp_q.push_back(mk(0, 16, 2, 2));
    act_q = '{3'd2, 3'd3};
    send_actions();
    wait_seq("t3");

    // T4: DEPTH+3 actions; only the first DEPTH (all flips) run, then implicit op 0
    load_image(5'd8);
    act_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      act_q.push_back(3'(2 + (i % 4)));
      exp_q.push_back(mk(2 + (i % 4), 8, (i == 0) ? 0 : ((i % 2) ? 1 : 2), (i % 2) ? 2 : 1));
    end
    act_q.push_back(3'd6);
    act_q.push_back(3'd1);
    act_q.push_back(3'd0);
    exp_q.push_back(mk(0, 8, 2, 2));
    send_actions();
    chk("t4_err_overflow_set", int'(err_overflow), 1);
    wait_seq("t4");
    chk("t4_err_overflow_sticky", int'(err_overflow), 1);

    // T5: retained size 8, dp_ready low 5 cycles, stray dp_done in ISSUE
    dp_ready = 1'b0;
    exp_q.push_back(mk(7, 8, 0, 1));
    exp_q.push_back(mk(0, 4, 1, 1));
    act_q = '{3'd7, 3'd0};
    send_actions();
    chk("t5_err_overflow_cleared", int'(err_overflow), 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", int'(cmd_valid), 1);
      chk("t5_hold_op", int'(cmd_op), 7);
      chk("t5_hold_size", int'(cmd_size), 8);
      chk("t5_hold_src", int'(cmd_src_bank), 0);
      chk("t5_hold_dst", int'(cmd_dst_bank), 1);
      @(posedge clk);
      #1 dp_done = (i == 1);
    end
    dp_done = 1'b0;
    dp_ready = 1'b1;
    wait_seq("t5");

    // T6: reset while in WAIT
    load_image(5'd16);
    exp_q.push_back(mk(2, 16, 0, 1));
    act_q = '{3'd2, 3'd0};
    send_actions();
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_valid && dp_ready) begin
        acc = 1;
        break;
      end
    end
    chk("t6_accepted", acc, 1);
    @(posedge clk);
    #2;
    chk("t6_wait_cmd_valid", int'(cmd_valid), 0);
    chk("t6_wait_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_cmd_fields", int'({cmd_valid, cmd_op, cmd_size, cmd_src_bank, cmd_dst_bank}), 0);
    chk("t6_rst_flags", int'({seq_done, err_overflow}), 0);
    exp_q.delete();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (seq_done) seen = 1;
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (seq_done) seen = 1;
    end
    chk("t6_no_seq_done", seen, 0);
    tick();

    // T7: fresh set after reset
    load_image(5'd4);
    exp_q.push_back(mk(6, 4, 0, 1));
    exp_q.push_back(mk(0, 8, 1, 1));
    act_q = '{3'd6, 3'd0};
    send_actions();
    wait_seq("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
